// File: rtl/gf2m_mul_serial.sv
// rtl/gf2m_mul_serial.sv - digit-serial carry-less multiplier over GF(2)[x] with low/reduced/high modes
module gf2m_mul_serial #(
    parameter int           W    = 8,
    parameter int           D    = 2,
    parameter logic [W-1:0] POLY = 8'h1B
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_y,
    output logic         out_err
);

    localparam int NDIG = W / D;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int AW   = 2 * W - 1;

    generate
        if (W < 2 || D < 1 || D > W || (W % D) != 0 || POLY[0] != 1'b1) begin : g_bad_params
            $error("gf2m_mul_serial: illegal W/D/POLY combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RED  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [AW-1:0]   r_a_sh;
    logic [W-1:0]    r_b;
    logic [1:0]      r_mode;
    logic [AW-1:0]   r_acc;
    logic [KW-1:0]   r_k;
    logic [W-1:0]    r_y;
    logic            r_err;

    logic [AW-1:0]   w_pp;
    logic [AW-1:0]   w_acc_next;
    logic [AW-1:0]   w_red;
    logic [AW-1:0]   w_pfull;
    logic [W-1:0]    w_y;
    logic            w_last_digit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_last_digit = (r_k == KW'(NDIG - 1));

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid)     w_state_next = S_MUL;
            S_MUL:  if (w_last_digit) w_state_next = S_RED;
            S_RED:                    w_state_next = S_DONE;
            S_DONE: if (out_ready)    w_state_next = S_IDLE;
            default:                  w_state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (r_state == S_IDLE) && !rst;
        out_valid = (r_state == S_DONE);
    end

    assign out_y   = r_y;
    assign out_err = r_err;

    // a is pre-shifted by k*D and b consumed from its low end, so each cycle needs only D AND/XOR rows
    always_comb begin
        w_pp = '0;
        for (int j = 0; j < D; j++) begin
            if (r_b[j]) begin
                w_pp = w_pp ^ (r_a_sh << j);
            end
        end
        w_acc_next = r_acc ^ w_pp;
    end

    assign w_pfull = AW'({1'b1, POLY});

    // Fold every coefficient above x^(W-1) back down, highest first, so the result is fully reduced
    always_comb begin
        w_red = r_acc;
        for (int i = AW - 1; i >= W; i--) begin
            if (w_red[i]) begin
                w_red = w_red ^ (w_pfull << (i - W));
            end
        end
    end

    always_comb begin
        w_y = '0;
        case (r_mode)
            2'd0:    w_y = r_acc[W-1:0];
            2'd1:    w_y = w_red[W-1:0];
            2'd2:    w_y = {1'b0, r_acc[AW-1:W]};
            default: w_y = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b    <= '0;
            r_mode <= '0;
            r_acc  <= '0;
            r_k    <= '0;
            r_y    <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sh <= AW'(in_a);
                        r_b    <= in_b;
                        r_mode <= in_mode;
                        r_acc  <= '0;
                        r_k    <= '0;
                    end
                end
                S_MUL: begin
                    r_acc  <= w_acc_next;
                    r_a_sh <= r_a_sh << D;
                    r_b    <= r_b >> D;
                    r_k    <= r_k + KW'(1);
                end
                S_RED: begin
                    r_y   <= w_y;
                    r_err <= (r_mode == 2'd3);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_mul_serial.sv
// tb/tb_gf2m_mul_serial.sv - self-checking bench for gf2m_mul_serial
module tb_gf2m_mul_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;
    int reg_done_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic mark_done();
        reg_done_cnt++;
    endtask

    // Bit-level reference: schoolbook product, Horner-style field multiply for the reduced mode
    function automatic logic [32:0] ref_mul(input int w, input logic [31:0] poly,
                                            input logic [31:0] a, input logic [31:0] b, input int mode);
        logic [63:0] p;
        logic [31:0] r;
        logic [31:0] mask;
        logic        msb;
        mask = 32'((64'd1 << w) - 64'd1);
        p = '0;
        for (int i = 0; i < w; i++)
            for (int j = 0; j < w; j++)
                if (a[i] && b[j]) p[i+j] = ~p[i+j];
        case (mode)
            0: return {1'b0, p[31:0] & mask};
            2: return {1'b0, 32'(p >> w) & mask};
            1: begin
                r = '0;
                for (int j = w - 1; j >= 0; j--) begin
                    msb = r[w-1];
                    r = (r << 1) & mask;
                    if (msb) r = r ^ poly;
                    if (b[j]) r = r ^ a;
                end
                return {1'b0, r};
            end
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       out_err;

    gf2m_mul_serial #(.W(8), .D(2), .POLY(8'h1B)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_err   (out_err)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] mode;
        logic [7:0] y;
        logic       err;
    } vec_t;

    vec_t       vecs[10];
    logic [8:0] exp_q[$];

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                          input logic [7:0] ey, input logic ee, input string name);
        int         t;
        int         acc_edge;
        logic [8:0] e;
        @(negedge clk);
        in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
        #1;
        t = 0;
        while (!in_ready && t < 50) begin @(negedge clk); #1; t++; end
        check({name, " accept"}, 64'(in_ready), 64'd1);
        acc_edge = cyc + 1;
        exp_q.push_back({ee, ey});
        @(negedge clk);
        in_valid = 1'b0;
        in_a = 8'($urandom); in_b = 8'($urandom); in_mode = 2'($urandom);
        t = 0;
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        check({name, " latency"}, 64'(cyc - acc_edge), 64'd5);
        e = exp_q.pop_front();
        check({name, " y"}, 64'(out_y), 64'(e[7:0]));
        check({name, " err"}, 64'(out_err), 64'(e[8]));
        if (out_ready) begin
            @(negedge clk);
            check({name, " ready after"}, 64'({in_ready, out_valid}), 64'b10);
        end
    endtask

    logic rst_r = 1'b1;
    initial begin
        repeat (2) @(negedge clk);
        rst_r = 1'b0;
    end

    localparam int NREG = 3;
    localparam int NOPS = 60;

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        localparam int          GW = (g == 0) ? 8 : (g == 1) ? 16 : 13;
        localparam int          GD = (g == 0) ? 1 : (g == 1) ? 4 : 13;
        localparam logic [31:0] GP = (g == 1) ? 32'h2B : 32'h1B;

        logic          iv, ir, ov, ordy, oe;
        logic [GW-1:0] ia, ib, oy;
        logic [1:0]    im;
        logic [32:0]   q[$];
        int            sent = 0;
        int            recv = 0;

        gf2m_mul_serial #(.W(GW), .D(GD), .POLY(GP[GW-1:0])) u_dut (
            .clk       (clk),
            .rst       (rst_r),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_a      (ia),
            .in_b      (ib),
            .in_mode   (im),
            .out_valid (ov),
            .out_ready (ordy),
            .out_y     (oy),
            .out_err   (oe)
        );

        always @(negedge clk) begin
            ordy = 1'($urandom_range(0, 1));
            #1;
            if (!rst_r && ov && ordy) begin
                if (q.size() == 0) check($sformatf("reg w%0d d%0d dup", GW, GD), 64'd1, 64'd0);
                else check($sformatf("reg w%0d d%0d y", GW, GD), 64'({oe, 32'(oy)}), 64'(q.pop_front()));
                recv++;
            end
        end

        initial begin
            int t;
            iv = 1'b0; ia = '0; ib = '0; im = '0;
            wait (!rst_r);
            for (int n = 0; n < NOPS; n++) begin
                @(negedge clk);
                ia = GW'($urandom); ib = GW'($urandom); im = 2'($urandom_range(0, 3));
                iv = 1'b1;
                #1;
                t = 0;
                while (!ir && t < 200) begin @(negedge clk); #1; t++; end
                if (!ir) check($sformatf("reg w%0d accept timeout", GW), 64'd0, 64'd1);
                else begin
                    q.push_back(ref_mul(GW, GP, 32'(ia), 32'(ib), int'(im)));
                    sent++;
                end
                @(negedge clk);
                iv = 1'b0;
                ia = GW'($urandom); ib = GW'($urandom); im = 2'($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            t = 0;
            while (recv < sent && t < 500) begin @(negedge clk); t++; end
            check($sformatf("reg w%0d d%0d count", GW, GD), 64'(recv), 64'(NOPS));
            check($sformatf("reg w%0d d%0d leftover", GW, GD), 64'(q.size()), 64'd0);
            mark_done();
        end
    end

    initial begin
        int   t;
        logic seen;
        vecs[0] = '{8'h57, 8'h83, 2'd0, 8'h79, 1'b0};
        vecs[1] = '{8'h57, 8'h83, 2'd2, 8'h2B, 1'b0};
        vecs[2] = '{8'h57, 8'h83, 2'd1, 8'hC1, 1'b0};
        vecs[3] = '{8'h02, 8'h80, 2'd1, 8'h1B, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 2'd0, 8'h55, 1'b0};
        vecs[5] = '{8'hA5, 8'h3C, 2'd3, 8'h00, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 2'd2, 8'h55, 1'b0};
        vecs[7] = '{8'h00, 8'hFF, 2'd0, 8'h00, 1'b0};
        vecs[8] = '{8'h01, 8'h01, 2'd1, 8'h01, 1'b0};
        vecs[9] = '{8'h80, 8'h80, 2'd2, 8'h40, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("in_ready during rst", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("reset outputs", 64'({in_ready, out_valid, out_err, out_y}), {53'd0, 3'b100, 8'h00});

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].y, vecs[i].err, $sformatf("vec%0d", i));

        // Backpressure: result held, new requests ignored
        out_ready = 1'b0;
        run_op(8'h57, 8'h83, 2'd1, 8'hC1, 1'b0, "bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_mode = 2'd0;
            #1;
            check($sformatf("bp hold %0d", i), 64'({out_valid, in_ready, out_err, out_y}), {53'd0, 3'b100, 8'hC1});
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("bp release", 64'({in_ready, out_valid}), 64'b10);
        run_op(8'hFF, 8'hFF, 2'd0, 8'h55, 1'b0, "bp next");

        // Reset in the second MUL cycle
        @(negedge clk);
        in_a = 8'h57; in_b = 8'h83; in_mode = 2'd0; in_valid = 1'b1;
        #1;
        check("abort accept", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort in_ready low", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort idle", 64'({in_ready, out_valid}), 64'b10);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort no result", 64'(seen), 64'd0);
        run_op(8'h03, 8'h03, 2'd0, 8'h05, 1'b0, "after abort");
        check("directed queue empty", 64'(exp_q.size()), 64'd0);

        t = 0;
        while (reg_done_cnt < NREG && t < 20000) begin @(negedge clk); t++; end
        check("regression done", 64'(reg_done_cnt), 64'(NREG));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gf2m_mul_serial.md
# gf2m_mul_serial

Parametrised, digit-serial carry-less multiplier over GF(2)[x], registered behind valid/ready handshakes. It generalises the fixed 8-bit combinational truncated product (y = a·b mod x^8) to any width W and digit size D, and adds two modes: reduction modulo a fixed irreducible polynomial (GF(2^W) field multiply) and high-half output. It sits between operand-staging logic and GF consumers (CRC/ECC/cipher datapaths), trading latency for area.

## Interface
- W, 8: operand/result width; W ≥ 2.
- D, 2: digit size, bits of b consumed per cycle; 1 ≤ D ≤ W and W % D == 0; elaboration error otherwise.
- POLY, 8'h1B: low W coefficients of reduction polynomial x^W + POLY; bit 0 must be 1.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- in_a  in  W  multiplicand polynomial, bit i = coefficient of x^i.
- in_b  in  W  multiplier polynomial.
- in_mode  in  2  0 = low half (a·b mod x^W), 1 = reduced (a·b mod (x^W+POLY)), 2 = high half (bits [2W-1:W] of product), 3 = reserved.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_y  out  W  result.
- out_err  out  1  result came from reserved mode.

## Operation
- States: IDLE, MUL, RED, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready: latch a, b, mode; clear 2W-1-bit accumulator acc; digit counter k = 0; go MUL.
- MUL: per cycle acc ^= (a ⊗ b[k·D +: D]) << (k·D), ⊗ = carry-less (AND/XOR only, no carries); k++. After W/D cycles go RED.
- RED (always one cycle, every mode): mode 0 → out_y = acc[W-1:0]; mode 1 → out_y = acc mod (x^W+POLY), fully reduced combinationally over the W-1 high bits; mode 2 → out_y = {1'b0, acc[2W-2:W]}; mode 3 → out_y = 0, out_err = 1. Go DONE.
- DONE: out_valid = 1; out_y, out_err stable until out_valid && out_ready, then IDLE.
- in_ready = 0 in MUL, RED, DONE, and while rst is high. Inputs ignored outside IDLE; latched copies unaffected by later input changes.
- Mode 0 result equals the existing combinational 8-bit truncated product for W = 8.

## Timing
- Reset values: state IDLE, out_valid 0, out_y 0, out_err 0, acc 0, k 0; in_ready 1 from first cycle after rst deasserts.
- Latency: accept at edge t → out_valid high from edge t + W/D + 1 (W=8, D=2: 5 cycles).
- out_ready high when out_valid rises: result consumed that cycle, in_ready high next cycle. Minimum issue interval W/D + 3 cycles.
- out_ready low: DONE held indefinitely, no result loss or change.
- out_ready asserted without out_valid: no effect.
- rst mid-operation (MUL/RED/DONE): aborts; next cycle IDLE, out_valid 0, pending result discarded.
- D = W: single MUL cycle, latency 2.

## Test plan
- W=8, D=2, mode 0, a=0x57, b=0x83 → out_y=0x79, out_err=0, out_valid exactly 5 cycles after accept.
- Same operands, mode 2 → out_y=0x2B; mode 1 → out_y=0xC1 (AES GF(2^8) product).
- Mode 1, a=0x02, b=0x80 → 0x1B; mode 0, a=0xFF, b=0xFF → 0x55; mode 3 any operands → out_y=0x00, out_err=1.
- Backpressure: hold out_ready low 10 cycles after out_valid → out_y stable, in_ready 0, new in_valid ignored; release → consumed, in_ready 1 next cycle, then next op accepted.
- Assert rst in 2nd MUL cycle → out_valid never rises for that op; following op a=0x03, b=0x03 mode 0 → 0x05.
- Random regression, W ∈ {8,16,13}, D ∈ divisors of W, all modes, random out_ready → matches bit-level GF(2) reference model; no lost or duplicated results.
